// File: rtl/gb_mem_requester_if.sv
// Bundle for gb_mem_requester: GB command and word streams plus the Memory
// single-word read/write handshake.
interface gb_mem_requester_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              read_mem;
  logic              write_mem;
  logic [ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0] mem_wdata;
  logic              done_mem;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              xfer_done;
  logic              xfer_err;

  modport master (
    input  cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data,
           rd_ready, done_mem, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, read_mem, write_mem,
           addr_mem, mem_wdata, busy, xfer_done, xfer_err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data,
           rd_ready, done_mem, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, read_mem, write_mem,
           addr_mem, mem_wdata, busy, xfer_done, xfer_err
  );
endinterface

// File: rtl/gb_mem_requester.sv
// Splits GB block-transfer commands into single-word Memory accesses, streaming
// read words to the GB and pulling write words from it.
module gb_mem_requester #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  gb_mem_requester_if.master bus
);
  localparam int unsigned SUM_W     = LEN_W + 1;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;
  localparam int unsigned TCNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ACCESS, S_RELEASE, S_PUSH, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              dir_q, dir_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [SUM_W-1:0]  cmd_sum;
  logic              cmd_bad;
  logic [LEN_W-1:0]  idx_inc;
  logic              last;

  // Command rejected when empty or when it would run past the top of Memory.
  assign cmd_sum = SUM_W'(bus.cmd_base) + SUM_W'(bus.cmd_len);
  assign cmd_bad = (bus.cmd_len == '0) || (cmd_sum > SUM_W'(MEM_WORDS));
  assign idx_inc = idx_q + LEN_W'(1);
  assign last    = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    dir_d     = dir_q;
    idx_d     = idx_q;
    tcnt_d    = tcnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          base_d = bus.cmd_base;
          len_d  = bus.cmd_len;
          dir_d  = bus.cmd_write;
          idx_d  = '0;
          if (cmd_bad) begin
            err_d = 1'b1;
          end else if (bus.cmd_write) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_ACCESS;
            addr_d  = bus.cmd_base;
            tcnt_d  = '0;
          end
        end
      end
      S_FETCH: begin
        if (bus.wr_valid) begin
          wdata_d = bus.wr_data;
          addr_d  = ADDR_W'(SUM_W'(base_q) + SUM_W'(idx_q));
          tcnt_d  = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus.done_mem) begin
          if (!dir_q) rd_data_d = bus.mem_rdata;
          state_d = S_RELEASE;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      // One cycle with both enables low so the Memory rearms its counter.
      S_RELEASE: begin
        if (!dir_q) begin
          state_d = S_PUSH;
        end else if (last) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_inc;
          state_d = S_FETCH;
        end
      end
      S_PUSH: begin
        if (bus.rd_ready) begin
          if (last) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_inc;
            addr_d  = ADDR_W'(SUM_W'(base_q) + SUM_W'(idx_inc));
            tcnt_d  = '0;
            state_d = S_ACCESS;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    read_d     = (state_d == S_ACCESS) && !dir_d;
    write_d    = (state_d == S_ACCESS) && dir_d;
    rd_valid_d = (state_d == S_PUSH);
    done_d     = (state_d == S_FINISH);
    busy_d     = state_d inside {S_FETCH, S_ACCESS, S_RELEASE, S_PUSH};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      read_q     <= read_d;
      write_q    <= write_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = (state_q == S_FETCH);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.read_mem  = read_q;
  assign bus.write_mem = write_q;
  assign bus.addr_mem  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.xfer_done = done_q;
  assign bus.xfer_err  = err_q;
endmodule

// File: tb/tb_gb_mem_requester.sv
// Bench for gb_mem_requester: Memory responder with fixed latency, GB driver,
// and an array reference of expected Memory contents.
module tb_gb_mem_requester;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned TIMEOUT   = 255;
  localparam int          MEM_WORDS = 2048;
  localparam int          MEM_LAT   = 101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gb_mem_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  gb_mem_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] init_word(input int unsigned a);
    return {32'hC0DE_0000 | a, a * 32'h9E37_79B1};
  endfunction

  // Memory: responds MEM_LAT cycles after an enable rises, restarts when it drops.
  logic [DATA_W-1:0] mem [MEM_WORDS];
  bit                mem_wr [MEM_WORDS];
  int                mcnt = 0;
  bit                mem_dead = 1'b0;

  always @(posedge clk) begin
    if (bus.read_mem || bus.write_mem) begin
      if (mcnt == MEM_LAT - 1 && !mem_dead) begin
        bus.done_mem <= 1'b1;
        if (bus.write_mem) begin
          mem[bus.addr_mem]    = bus.mem_wdata;
          mem_wr[bus.addr_mem] = 1'b1;
        end else begin
          bus.mem_rdata <= mem_wr[bus.addr_mem] ? mem[bus.addr_mem] : init_word(32'(bus.addr_mem));
        end
      end else begin
        bus.done_mem <= 1'b0;
      end
      mcnt <= mcnt + 1;
    end else begin
      mcnt         <= 0;
      bus.done_mem <= 1'b0;
    end
  end

  function automatic logic [63:0] mem_view(input int a);
    return mem_wr[a] ? mem[a] : init_word(32'(a));
  endfunction

  // Enable-run monitor: length and address of every Memory access.
  int               both_hi = 0, rd_overlap = 0, addr_unstable = 0, run_len = 0;
  int               runs[$];
  logic [ADDR_W-1:0] run_addr[$];
  bit               prev_en = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (bus.read_mem && bus.write_mem) both_hi++;
    if (bus.rd_valid && bus.read_mem) rd_overlap++;
    if (bus.read_mem || bus.write_mem) begin
      if (!prev_en) begin
        run_len = 1;
        run_addr.push_back(bus.addr_mem);
      end else begin
        run_len++;
        if (bus.addr_mem !== prev_addr) addr_unstable++;
      end
    end else if (prev_en) begin
      runs.push_back(run_len);
    end
    prev_en   = bus.read_mem || bus.write_mem;
    prev_addr = bus.addr_mem;
  end

  logic [63:0] ref_mem [MEM_WORDS];
  logic [63:0] wq[$];
  logic [63:0] rq[$];
  int          run0;
  bit          x_done, x_err;
  int          x_cycles, x_busy, x_stall_bad;

  // Issues one command and serves the GB side until xfer_done/xfer_err or budget expiry.
  task automatic do_xfer(input bit wr, input int base, input int len,
                         input int stall_beat, input int stall_cyc, input bit rnd);
    int wi = 0, beat = 0, stall = 0;
    bit wr_hs = 1'b0, fin = 1'b0;
    logic [63:0] held = '0;
    int budget;
    budget = len * 400 + 600;
    rq.delete();
    x_done = 1'b0; x_err = 1'b0; x_busy = 0; x_stall_bad = 0; x_cycles = -1;
    run0 = runs.size();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_base  = ADDR_W'(base);
    bus.cmd_len   = LEN_W'(len);
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (wr_hs) begin wi++; wr_hs = 1'b0; end
      if (bus.busy) x_busy++;
      if (bus.xfer_done || bus.xfer_err) begin
        x_done = bus.xfer_done; x_err = bus.xfer_err; x_cycles = cyc; fin = 1'b1;
      end
      bus.wr_valid = wr && (wi < wq.size()) && (!rnd || $urandom_range(0, 2) != 0);
      bus.wr_data  = (wi < wq.size()) ? wq[wi] : '0;
      if (bus.wr_valid && bus.wr_ready) wr_hs = 1'b1;
      if (bus.rd_valid && beat == stall_beat && stall < stall_cyc) begin
        if (stall == 0) held = bus.rd_data;
        else if (bus.rd_data !== held) x_stall_bad++;
        stall++;
        bus.rd_ready = 1'b0;
      end else begin
        bus.rd_ready = !rnd || ($urandom_range(0, 2) != 0);
        if (bus.rd_valid && bus.rd_ready) begin
          if (stall > 0 && beat == stall_beat && bus.rd_data !== held) x_stall_bad++;
          rq.push_back(bus.rd_data);
          beat++;
        end
      end
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.wr_ready, bus.rd_valid, bus.read_mem, bus.write_mem, bus.busy, bus.xfer_done, bus.xfer_err} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000000",
        {bus.wr_ready, bus.rd_valid, bus.read_mem, bus.write_mem, bus.busy, bus.xfer_done, bus.xfer_err});
    end
    checks++;
    if (bus.addr_mem !== '0 || bus.rd_data !== '0 || bus.mem_wdata !== '0) begin
      errors++; $display("FAIL reset_data got addr %0h rd %0h wd %0h exp 0", bus.addr_mem, bus.rd_data, bus.mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    do_xfer(1'b0, 800, 3, -1, 0, 1'b0);
    checks++;
    if (!(x_done && !x_err)) begin errors++; $display("FAIL read_done got done %b err %b exp 1 0", x_done, x_err); end
    checks++;
    if (rq.size() != 3) begin errors++; $display("FAIL read_beats got %0d exp 3", rq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rq[i] !== ref_mem[800 + i]) begin errors++; $display("FAIL read_data[%0d] got %h exp %h", i, rq[i], ref_mem[800 + i]); end
    end
    checks++;
    if (runs.size() - run0 != 3) begin errors++; $display("FAIL read_accesses got %0d exp 3", runs.size() - run0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (runs[run0 + i] != MEM_LAT + 1 || run_addr[run0 + i] !== ADDR_W'(800 + i)) begin
        errors++; $display("FAIL read_enable[%0d] got len %0d addr %0d exp len %0d addr %0d",
          i, runs[run0 + i], run_addr[run0 + i], MEM_LAT + 1, 800 + i);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL read_idle got busy %b cmd_ready %b exp 0 1", bus.busy, bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    wq = {64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000};
    do_xfer(1'b1, 1100, 2, -1, 0, 1'b0);
    ref_mem[1100] = 64'h3FF0_0000_0000_0000;
    ref_mem[1101] = 64'h4000_0000_0000_0000;
    checks++;
    if (!(x_done && !x_err)) begin errors++; $display("FAIL write_done got done %b err %b exp 1 0", x_done, x_err); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_view(1100 + i) !== ref_mem[1100 + i]) begin
        errors++; $display("FAIL write_mem[%0d] got %h exp %h", 1100 + i, mem_view(1100 + i), ref_mem[1100 + i]);
      end
    end
    checks++;
    if (runs.size() - run0 != 2 || runs[run0] != MEM_LAT + 1 || run_addr[run0 + 1] !== ADDR_W'(1101)) begin
      errors++; $display("FAIL write_enable got n %0d len %0d addr1 %0d exp 2 %0d 1101",
        runs.size() - run0, runs[run0], run_addr[run0 + 1], MEM_LAT + 1);
    end
  endtask

  task automatic test_backpressure();
    int ov0;
    ov0 = rd_overlap;
    do_xfer(1'b0, 1500, 2, 0, 50, 1'b0);
    checks++;
    if (!(x_done && !x_err) || rq.size() != 2) begin
      errors++; $display("FAIL bp_done got done %b beats %0d exp 1 2", x_done, rq.size());
    end
    checks++;
    if (x_stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", x_stall_bad); end
    checks++;
    if (rd_overlap != ov0) begin errors++; $display("FAIL bp_no_read_while_valid got %0d exp 0", rd_overlap - ov0); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rq[i] !== ref_mem[1500 + i]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, rq[i], ref_mem[1500 + i]); end
    end
  endtask

  task automatic test_reject();
    int bases[2] = '{2047, 0};
    int lens[2]  = '{2, 0};
    for (int k = 0; k < 2; k++) begin
      wq.delete();
      do_xfer(k == 1, bases[k], lens[k], -1, 0, 1'b0);
      checks++;
      if (!(x_err && !x_done) || x_cycles != 0) begin
        errors++; $display("FAIL reject%0d got err %b done %b at %0d exp 1 0 at 0", k, x_err, x_done, x_cycles);
      end
      checks++;
      if (x_busy != 0 || runs.size() != run0) begin
        errors++; $display("FAIL reject%0d_quiet got busy %0d accesses %0d exp 0 0", k, x_busy, runs.size() - run0);
      end
    end
    do_xfer(1'b0, 2047, 1, -1, 0, 1'b0);
    checks++;
    if (!x_done || rq.size() != 1 || rq[0] !== ref_mem[2047]) begin
      errors++; $display("FAIL top_word_read got done %b data %h exp 1 %h", x_done, rq[0], ref_mem[2047]);
    end
  endtask

  task automatic test_timeout();
    mem_dead = 1'b1;
    do_xfer(1'b0, 5, 1, -1, 0, 1'b0);
    mem_dead = 1'b0;
    checks++;
    if (!(x_err && !x_done) || rq.size() != 0) begin
      errors++; $display("FAIL timeout_err got err %b done %b beats %0d exp 1 0 0", x_err, x_done, rq.size());
    end
    checks++;
    if (runs.size() - run0 != 1 || runs[run0] != int'(TIMEOUT)) begin
      errors++; $display("FAIL timeout_len got %0d exp %0d", runs[run0], TIMEOUT);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got cmd_ready %b busy %b exp 1 0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_base = ADDR_W'(300); bus.cmd_len = LEN_W'(1);
    bus.wr_valid = 1'b1; bus.wr_data = {$urandom, $urandom};
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    while (!bus.write_mem && k < 20) begin @(negedge clk); k++; end
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.write_mem !== 1'b1) begin errors++; $display("FAIL rstmid_start got write_mem %b exp 1", bus.write_mem); end
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.write_mem !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.xfer_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort got wm %b busy %b rdy %b err %b exp 0 0 1 0",
        bus.write_mem, bus.busy, bus.cmd_ready, bus.xfer_err);
    end
    repeat (2) @(negedge clk);
    do_xfer(1'b0, 300, 1, -1, 0, 1'b0);
    checks++;
    if (!x_done || rq[0] !== ref_mem[300]) begin
      errors++; $display("FAIL rstmid_reread got done %b data %h exp 1 %h", x_done, rq[0], ref_mem[300]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      bit wr, bad;
      int len, base;
      wr  = 1'($urandom_range(0, 1));
      bad = (n % 4 == 3);
      if (bad) begin
        len  = $urandom_range(2, 8);
        base = MEM_WORDS - len + $urandom_range(1, len - 1);
      end else begin
        len  = $urandom_range(1, 4);
        base = (n == 0) ? MEM_WORDS - len : $urandom_range(0, MEM_WORDS - len);
      end
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back({$urandom, $urandom});
      do_xfer(wr, base, len, -1, 0, 1'b1);
      checks++;
      if (x_err !== bad || x_done !== !bad) begin
        errors++; $display("FAIL rnd%0d_status base %0d len %0d got done %b err %b exp err %b", n, base, len, x_done, x_err, bad);
      end
      if (!bad && wr) begin
        for (int i = 0; i < len; i++) ref_mem[base + i] = wq[i];
        for (int i = 0; i < len; i++) begin
          checks++;
          if (mem_view(base + i) !== ref_mem[base + i]) begin
            errors++; $display("FAIL rnd%0d_wr[%0d] got %h exp %h", n, base + i, mem_view(base + i), ref_mem[base + i]);
          end
        end
      end else if (!bad) begin
        checks++;
        if (rq.size() != len) begin errors++; $display("FAIL rnd%0d_beats got %0d exp %0d", n, rq.size(), len); end
        for (int i = 0; i < len; i++) begin
          checks++;
          if (rq[i] !== ref_mem[base + i]) begin
            errors++; $display("FAIL rnd%0d_rd[%0d] got %h exp %h", n, base + i, rq[i], ref_mem[base + i]);
          end
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (both_hi != 0 || addr_unstable != 0) begin
      errors++; $display("FAIL invariants got both_hi %0d addr_moves %0d exp 0 0", both_hi, addr_unstable);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(32'(i));
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_reject();
    test_timeout();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1);
  end
endmodule
